// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with programmable almost-full/empty levels, occupancy count and sticky error flags.
// Latency: standard mode 1 cycle from accepted read to dataOut; FWFT mode shows the head word 1 cycle after its write.
// Backpressure: writes while full and reads while empty are dropped and latch overflowOut/underflowOut.
module sync_fifo_flags #(
  parameter int dataWidth = 8,
  parameter int addrWidth = 3,
  parameter bit fwftMode  = 1'b0
) (
  input  logic                 clkIn,
  input  logic                 rstIn,
  input  logic [dataWidth-1:0] dataIn,
  input  logic                 writeEnableIn,
  input  logic                 readEnableIn,
  input  logic [addrWidth:0]   almostFullLevelIn,
  input  logic [addrWidth:0]   almostEmptyLevelIn,
  input  logic                 errClearIn,
  output logic [dataWidth-1:0] dataOut,
  output logic                 dataValidOut,
  output logic                 fifoFullOut,
  output logic                 fifoEmptyOut,
  output logic                 almostFullOut,
  output logic                 almostEmptyOut,
  output logic [addrWidth:0]   countOut,
  output logic                 overflowOut,
  output logic                 underflowOut
);

  localparam int depth = 1 << addrWidth;
  localparam logic [addrWidth:0] depthCount = {1'b1, {addrWidth{1'b0}}};
  localparam logic [addrWidth:0] oneCount   = {{addrWidth{1'b0}}, 1'b1};

  logic [dataWidth-1:0] mem [depth];
  logic [addrWidth:0]   wrPtr;
  logic [addrWidth:0]   rdPtr;
  logic [addrWidth:0]   count;
  logic                 wrAccept;
  logic                 rdAccept;
  logic                 wrReject;
  logic                 rdReject;

  // Flags decode only from the count register, never from the enables.
  assign fifoFullOut    = (count == depthCount);
  assign fifoEmptyOut   = (count == '0);
  assign almostFullOut  = (count >= almostFullLevelIn);
  assign almostEmptyOut = (count <= almostEmptyLevelIn);
  assign countOut       = count;

  assign wrAccept = writeEnableIn & ~fifoFullOut;
  assign wrReject = writeEnableIn &  fifoFullOut;
  assign rdAccept = readEnableIn  & ~fifoEmptyOut;
  assign rdReject = readEnableIn  &  fifoEmptyOut;

  // Storage array is not reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clkIn) begin
    if (rstIn && wrAccept) begin
      mem[wrPtr[addrWidth-1:0]] <= dataIn;
    end
  end

  // Pointers wrap modulo 2^(addrWidth+1); count tracks net accepted writes minus reads.
  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrAccept) wrPtr <= wrPtr + oneCount;
      if (rdAccept) rdPtr <= rdPtr + oneCount;
      case ({wrAccept, rdAccept})
        2'b10:   count <= count + oneCount;
        2'b01:   count <= count - oneCount;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new rejection in the clear cycle keeps the flag set.
  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      overflowOut  <= 1'b0;
      underflowOut <= 1'b0;
    end else begin
      overflowOut  <= wrReject | (overflowOut  & ~errClearIn);
      underflowOut <= rdReject | (underflowOut & ~errClearIn);
    end
  end

  generate
    if (fwftMode) begin : gFwft
      // Head word is presented directly; masked to zero when empty so reset state reads as 0.
      assign dataValidOut = ~fifoEmptyOut;
      assign dataOut      = fifoEmptyOut ? '0 : mem[rdPtr[addrWidth-1:0]];
    end else begin : gStd
      logic [dataWidth-1:0] dataReg;
      logic                 validReg;

      // Registered read: one-cycle valid pulse per accepted read, data held otherwise.
      always_ff @(posedge clkIn) begin
        if (!rstIn) begin
          dataReg  <= '0;
          validReg <= 1'b0;
        end else if (rdAccept) begin
          dataReg  <= mem[rdPtr[addrWidth-1:0]];
          validReg <= 1'b1;
        end else begin
          validReg <= 1'b0;
        end
      end

      assign dataOut      = dataReg;
      assign dataValidOut = validReg;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: standard-mode and FWFT-mode instances share stimulus.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: a bench-side occupancy model decides which requests the DUT must accept.
module tb_sync_fifo_flags;

  logic       clk;
  logic       rstIn;
  logic [7:0] dataIn;
  logic       writeEnableIn;
  logic       readEnableIn;
  logic [3:0] almostFullLevelIn;
  logic [3:0] almostEmptyLevelIn;
  logic       errClearIn;

  logic [7:0] sData;
  logic       sValid, sFull, sEmpty, sAF, sAE, sOvf, sUnf;
  logic [3:0] sCount;
  logic [7:0] fData;
  logic       fValid, fFull, fEmpty, fAF, fAE, fOvf, fUnf;
  logic [3:0] fCount;

  int passCnt  = 0;
  int totalCnt = 0;
  int modelCount = 0;
  logic [7:0] expQ [$];
  logic [7:0] expWord;

  sync_fifo_flags #(.dataWidth(8), .addrWidth(3), .fwftMode(1'b0)) uStd (
    .clkIn(clk), .rstIn(rstIn), .dataIn(dataIn),
    .writeEnableIn(writeEnableIn), .readEnableIn(readEnableIn),
    .almostFullLevelIn(almostFullLevelIn), .almostEmptyLevelIn(almostEmptyLevelIn),
    .errClearIn(errClearIn),
    .dataOut(sData), .dataValidOut(sValid), .fifoFullOut(sFull), .fifoEmptyOut(sEmpty),
    .almostFullOut(sAF), .almostEmptyOut(sAE), .countOut(sCount),
    .overflowOut(sOvf), .underflowOut(sUnf)
  );

  sync_fifo_flags #(.dataWidth(8), .addrWidth(3), .fwftMode(1'b1)) uFwft (
    .clkIn(clk), .rstIn(rstIn), .dataIn(dataIn),
    .writeEnableIn(writeEnableIn), .readEnableIn(readEnableIn),
    .almostFullLevelIn(almostFullLevelIn), .almostEmptyLevelIn(almostEmptyLevelIn),
    .errClearIn(errClearIn),
    .dataOut(fData), .dataValidOut(fValid), .fifoFullOut(fFull), .fifoEmptyOut(fEmpty),
    .almostFullOut(fAF), .almostEmptyOut(fAE), .countOut(fCount),
    .overflowOut(fOvf), .underflowOut(fUnf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of requests, update the model and scoreboard, sample after the edge.
  task automatic step(input bit we, input bit re, input logic [7:0] d, output bit rdOk);
    bit wrOk;
    wrOk = we && (modelCount < 8);
    rdOk = re && (modelCount > 0);
    writeEnableIn = we;
    readEnableIn  = re;
    dataIn        = d;
    if (wrOk) expQ.push_back(d);
    if (wrOk && !rdOk) modelCount++;
    if (rdOk && !wrOk) modelCount--;
    @(posedge clk);
    #1;
    writeEnableIn = 1'b0;
    readEnableIn  = 1'b0;
  endtask

  task automatic doReset(input int cycles);
    rstIn = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rstIn = 1'b1;
    modelCount = 0;
    expQ.delete();
  endtask

  task automatic test_reset();
    doReset(2);
    totalCnt++; if (sCount !== 4'd0) $display("FAIL reset_count got %0d expected 0", sCount); else passCnt++;
    totalCnt++; if (sEmpty !== 1'b1) $display("FAIL reset_empty got %b expected 1", sEmpty); else passCnt++;
    totalCnt++; if (sAE !== 1'b1) $display("FAIL reset_aempty got %b expected 1", sAE); else passCnt++;
    totalCnt++; if (sFull !== 1'b0) $display("FAIL reset_full got %b expected 0", sFull); else passCnt++;
    totalCnt++; if (sAF !== 1'b0) $display("FAIL reset_afull got %b expected 0", sAF); else passCnt++;
    totalCnt++; if (sValid !== 1'b0) $display("FAIL reset_valid got %b expected 0", sValid); else passCnt++;
    totalCnt++; if (sData !== 8'h00) $display("FAIL reset_data got %h expected 00", sData); else passCnt++;
    totalCnt++; if ({sOvf, sUnf} !== 2'b00) $display("FAIL reset_err got %b expected 00", {sOvf, sUnf}); else passCnt++;
    totalCnt++; if ({fValid, fData} !== 9'h000) $display("FAIL reset_fwft got %h expected 000", {fValid, fData}); else passCnt++;
  endtask

  task automatic test_fill_overflow();
    bit rdOk;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b0, 8'(i), rdOk);
      totalCnt++;
      if (sAF !== ((i + 1) >= 6)) $display("FAIL fill_afull_%0d got %b expected %b", i, sAF, ((i + 1) >= 6));
      else passCnt++;
      if (i == 7) begin
        totalCnt++; if (sFull !== 1'b1) $display("FAIL fill_full got %b expected 1", sFull); else passCnt++;
        totalCnt++; if (sCount !== 4'd8) $display("FAIL fill_count got %0d expected 8", sCount); else passCnt++;
        totalCnt++; if (sOvf !== 1'b0) $display("FAIL fill_ovf_early got %b expected 0", sOvf); else passCnt++;
      end
    end
    totalCnt++; if (sCount !== 4'd8) $display("FAIL ovf_count got %0d expected 8", sCount); else passCnt++;
    totalCnt++; if (sOvf !== 1'b1) $display("FAIL ovf_flag got %b expected 1", sOvf); else passCnt++;
    errClearIn = 1'b1;
    step(1'b0, 1'b0, 8'h00, rdOk);
    errClearIn = 1'b0;
    totalCnt++; if (sOvf !== 1'b0) $display("FAIL ovf_clear got %b expected 0", sOvf); else passCnt++;
  endtask

  task automatic test_drain_underflow();
    bit rdOk;
    int returned;
    returned = 0;
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b1, 8'h00, rdOk);
      totalCnt++;
      if (sValid !== rdOk) $display("FAIL drain_valid_%0d got %b expected %b", i, sValid, rdOk);
      else passCnt++;
      if (sValid === 1'b1) begin
        returned++;
        expWord = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
        totalCnt++;
        if (sData !== expWord) $display("FAIL drain_data_%0d got %h expected %h", i, sData, expWord);
        else passCnt++;
      end
    end
    totalCnt++; if (returned !== 8) $display("FAIL drain_returned got %0d expected 8", returned); else passCnt++;
    totalCnt++; if ({sEmpty, sAE} !== 2'b11) $display("FAIL drain_empty got %b expected 11", {sEmpty, sAE}); else passCnt++;
    totalCnt++; if (sUnf !== 1'b1) $display("FAIL unf_flag got %b expected 1", sUnf); else passCnt++;
    errClearIn = 1'b1;
    step(1'b0, 1'b0, 8'h00, rdOk);
    errClearIn = 1'b0;
    totalCnt++; if (sUnf !== 1'b0) $display("FAIL unf_clear got %b expected 0", sUnf); else passCnt++;
  endtask

  task automatic test_simultaneous();
    bit rdOk;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h30 + i), rdOk);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'(8'h40 + i), rdOk);
      totalCnt++;
      if (sCount !== 4'd4) $display("FAIL simul_count_%0d got %0d expected 4", i, sCount);
      else passCnt++;
      expWord = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
      totalCnt++;
      if ({sValid, sData} !== {1'b1, expWord}) $display("FAIL simul_data_%0d got %b/%h expected 1/%h", i, sValid, sData, expWord);
      else passCnt++;
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h60 + i), rdOk);
    step(1'b1, 1'b1, 8'hEE, rdOk);
    totalCnt++; if (sCount !== 4'd7) $display("FAIL full_rw_count got %0d expected 7", sCount); else passCnt++;
    totalCnt++; if (sOvf !== 1'b1) $display("FAIL full_rw_ovf got %b expected 1", sOvf); else passCnt++;
    expWord = expQ.pop_front();
    totalCnt++; if (sData !== expWord) $display("FAIL full_rw_data got %h expected %h", sData, expWord); else passCnt++;
    errClearIn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 8'h00, rdOk);
      errClearIn = 1'b0;
      expWord = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
      totalCnt++;
      if ({sValid, sData} !== {1'b1, expWord}) $display("FAIL full_rw_drain_%0d got %b/%h expected 1/%h", i, sValid, sData, expWord);
      else passCnt++;
    end
    step(1'b1, 1'b1, 8'h77, rdOk);
    totalCnt++; if (sCount !== 4'd1) $display("FAIL empty_rw_count got %0d expected 1", sCount); else passCnt++;
    totalCnt++; if (sUnf !== 1'b1) $display("FAIL empty_rw_unf got %b expected 1", sUnf); else passCnt++;
    totalCnt++; if (sValid !== 1'b0) $display("FAIL empty_rw_valid got %b expected 0", sValid); else passCnt++;
    errClearIn = 1'b1;
    step(1'b0, 1'b1, 8'h00, rdOk);
    errClearIn = 1'b0;
    expWord = expQ.pop_front();
    totalCnt++; if ({sValid, sData} !== {1'b1, expWord}) $display("FAIL empty_rw_data got %b/%h expected 1/%h", sValid, sData, expWord); else passCnt++;
    totalCnt++; if ({sUnf, sEmpty} !== 2'b01) $display("FAIL empty_rw_final got %b expected 01", {sUnf, sEmpty}); else passCnt++;
  endtask

  task automatic test_wrap();
    bit rdOk;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(p * 8 + i), rdOk);
      totalCnt++;
      if (sFull !== 1'b1) $display("FAIL wrap_full_%0d got %b expected 1", p, sFull);
      else passCnt++;
      for (int i = 0; i < 8; i++) begin
        step(1'b0, 1'b1, 8'h00, rdOk);
        expWord = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
        totalCnt++;
        if ({sValid, sData} !== {1'b1, expWord}) $display("FAIL wrap_data_%0d_%0d got %b/%h expected 1/%h", p, i, sValid, sData, expWord);
        else passCnt++;
      end
      totalCnt++;
      if (sEmpty !== 1'b1) $display("FAIL wrap_empty_%0d got %b expected 1", p, sEmpty);
      else passCnt++;
    end
  endtask

  task automatic test_fwft();
    bit rdOk;
    doReset(1);
    step(1'b1, 1'b0, 8'hA5, rdOk);
    totalCnt++; if ({fValid, fData} !== {1'b1, 8'hA5}) $display("FAIL fwft_first got %b/%h expected 1/a5", fValid, fData); else passCnt++;
    step(1'b0, 1'b1, 8'h00, rdOk);
    totalCnt++; if ({fValid, fEmpty} !== 2'b01) $display("FAIL fwft_empty got %b expected 01", {fValid, fEmpty}); else passCnt++;
    step(1'b1, 1'b0, 8'h11, rdOk);
    step(1'b1, 1'b0, 8'h22, rdOk);
    totalCnt++; if (fData !== 8'h11) $display("FAIL fwft_head got %h expected 11", fData); else passCnt++;
    step(1'b1, 1'b1, 8'h33, rdOk);
    totalCnt++; if ({fValid, fData, fCount} !== {1'b1, 8'h22, 4'd2}) $display("FAIL fwft_pop got %b/%h/%0d expected 1/22/2", fValid, fData, fCount); else passCnt++;
    rstIn = 1'b0;
    writeEnableIn = 1'b1;
    readEnableIn  = 1'b1;
    dataIn = 8'h99;
    @(posedge clk);
    #1;
    rstIn = 1'b1;
    writeEnableIn = 1'b0;
    readEnableIn  = 1'b0;
    modelCount = 0;
    expQ.delete();
    totalCnt++; if ({fCount, fValid, fData} !== 13'h0) $display("FAIL fwft_rst_data got %h/%b/%h expected 0/0/00", fCount, fValid, fData); else passCnt++;
    totalCnt++; if ({fEmpty, fFull, fAE, fAF, fOvf, fUnf} !== 6'b101000) $display("FAIL fwft_rst_flags got %b expected 101000", {fEmpty, fFull, fAE, fAF, fOvf, fUnf}); else passCnt++;
    totalCnt++; if ({sCount, sValid, sData} !== 13'h0) $display("FAIL std_rst_data got %h/%b/%h expected 0/0/00", sCount, sValid, sData); else passCnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rstIn = 1'b0;
    dataIn = 8'h00;
    writeEnableIn = 1'b0;
    readEnableIn = 1'b0;
    errClearIn = 1'b0;
    almostFullLevelIn = 4'd6;
    almostEmptyLevelIn = 4'd2;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_simultaneous();
    test_wrap();
    test_fwft();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
